// File: rtl/ctrl_ex_time_rpt.sv
// Exposure-time setting register: saturating up/down stepping from button levels
// with hold-to-repeat, a lock that freezes the value, and range status flags.
module ctrl_ex_time_rpt #(
  parameter int WIDTH         = 5,
  parameter int MIN_VAL       = 2,
  parameter int MAX_VAL       = 30,
  parameter int INIT_VAL      = 16,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_increase,
  input  logic             ex_decrease,
  input  logic             lock,
  output logic [WIDTH-1:0] ex_init,
  output logic             at_min,
  output logic             at_max,
  output logic             step_pulse
);

  localparam int MAX_DP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW     = $clog2(MAX_DP) + 1;

  localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] INIT_W   = WIDTH'(INIT_VAL);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1'b1);
  localparam logic [TW-1:0]    DLY_LD   = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]    PER_LD   = TW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0]    TMR_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0]    TMR_ONE  = TW'(1'b1);

  if (!(REPEAT_DELAY >= 1 && REPEAT_PERIOD >= 1 && WIDTH >= 1 && WIDTH <= 31 &&
        MIN_VAL >= 0 && MIN_VAL <= INIT_VAL && INIT_VAL <= MAX_VAL &&
        MAX_VAL <= (2 ** WIDTH) - 1)) begin : g_param_err
    $error("ctrl_ex_time_rpt: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t           state_r      = ST_IDLE;
  logic             dir_r        = 1'b0;
  logic [TW-1:0]    tmr_r        = {TW{1'b0}};
  logic [WIDTH-1:0] ex_init_r    = INIT_W;
  logic             step_pulse_r = 1'b0;
  logic             at_min_r     = (INIT_VAL == MIN_VAL);
  logic             at_max_r     = (INIT_VAL == MAX_VAL);

  logic             up_s;
  logic             dn_s;
  logic             req_s;
  logic             new_press_s;
  logic             repeat_s;
  logic             step_en_s;
  logic [WIDTH-1:0] step_val_s;
  logic             changed_s;
  logic [WIDTH-1:0] ex_next_s;

  assign up_s  = ex_increase & ~ex_decrease;
  assign dn_s  = ex_decrease & ~ex_increase;
  assign req_s = up_s | dn_s;

  // Step decision and saturated candidate value for this edge
  always_comb begin
    new_press_s = 1'b0;
    repeat_s    = 1'b0;
    if (req_s) begin
      if (state_r == ST_IDLE || up_s != dir_r) begin
        new_press_s = 1'b1;
      end else begin
        repeat_s = (tmr_r == TMR_ZERO);
      end
    end else begin
      new_press_s = 1'b0;
    end

    step_en_s = ~lock & (new_press_s | repeat_s);

    // A saturated step still counts for timing but leaves the value alone
    if (up_s) begin
      step_val_s = (ex_init_r < MAX_W) ? (ex_init_r + ONE_W) : ex_init_r;
    end else begin
      step_val_s = (ex_init_r > MIN_W) ? (ex_init_r - ONE_W) : ex_init_r;
    end

    changed_s = step_en_s & (step_val_s != ex_init_r);
    ex_next_s = changed_s ? step_val_s : ex_init_r;
  end

  // Exposure value, status flags, and repeat FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_init_r    <= INIT_W;
      step_pulse_r <= 1'b0;
      at_min_r     <= (INIT_W == MIN_W);
      at_max_r     <= (INIT_W == MAX_W);
      state_r      <= ST_IDLE;
      dir_r        <= 1'b0;
      tmr_r        <= TMR_ZERO;
    end else begin
      ex_init_r    <= ex_next_s;
      step_pulse_r <= changed_s;
      at_min_r     <= (ex_next_s == MIN_W);
      at_max_r     <= (ex_next_s == MAX_W);

      if (lock) begin
        state_r <= ST_IDLE;
        tmr_r   <= TMR_ZERO;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (new_press_s) begin
              state_r <= ST_DELAY;
              dir_r   <= up_s;
              tmr_r   <= DLY_LD;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_DELAY, ST_REPEAT: begin
            if (!req_s) begin
              state_r <= ST_IDLE;
              tmr_r   <= TMR_ZERO;
            end else if (new_press_s) begin
              state_r <= ST_DELAY;
              dir_r   <= up_s;
              tmr_r   <= DLY_LD;
            end else if (repeat_s) begin
              state_r <= ST_REPEAT;
              tmr_r   <= PER_LD;
            end else begin
              tmr_r   <= tmr_r - TMR_ONE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            tmr_r   <= TMR_ZERO;
          end
        endcase
      end
    end
  end

  assign ex_init    = ex_init_r;
  assign step_pulse = step_pulse_r;
  assign at_min     = at_min_r;
  assign at_max     = at_max_r;

endmodule

// File: doc/ctrl_ex_time_rpt.md
# ctrl_ex_time_rpt

Parametrised exposure-time setting register with hold-to-repeat. Converts the raw `ex_increase` / `ex_decrease` button levels into a saturating exposure value `ex_init`, stepping once per press and auto-repeating while a button is held. Sits between the button inputs and the exposure/readout FSM. It generalises the fixed 5-bit, [2,30] exposure control with configurable width, range and reset value, a lock input and status outputs.

## Interface
- `WIDTH`, 5: width of `ex_init`.
- `MIN_VAL`, 2: lower saturation bound.
- `MAX_VAL`, 30: upper saturation bound.
- `INIT_VAL`, 16: reset and power-up value of `ex_init`.
- `REPEAT_DELAY`, 8: held cycles from the first step to the first auto-repeat step. Must be ≥1.
- `REPEAT_PERIOD`, 4: cycles between subsequent auto-repeat steps. Must be ≥1.
- Legality: MIN_VAL ≤ INIT_VAL ≤ MAX_VAL ≤ 2^WIDTH−1. Out-of-range parameters are a static error (elaboration-time check).
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ex_increase`  in  1  increase request, level.
- `ex_decrease`  in  1  decrease request, level.
- `lock`  in  1  high while exposure is in progress. Freezes `ex_init`.
- `ex_init`  out  WIDTH  current exposure setting, registered.
- `at_min`  out  1  `ex_init == MIN_VAL`, decoded from the register.
- `at_max`  out  1  `ex_init == MAX_VAL`, decoded from the register.
- `step_pulse`  out  1  registered. High for exactly one cycle after each edge at which `ex_init` changed.

## Operation
- Request decode:
  - `up = ex_increase & ~ex_decrease`; `dn = ex_decrease & ~ex_increase`.
  - Both high or both low means no request.
- Repeat FSM has three states:
  - IDLE: no request held.
  - DELAY: first step done; waiting for the first repeat.
  - REPEAT: auto-repeating.
- FSM also holds a direction register `dir` and a down-counter `tmr`. `tmr` is ceil(log2(max(D,P)))+1 bits, with D = REPEAT_DELAY and P = REPEAT_PERIOD.
- IDLE:
  - Request present and `lock` low: step in the request direction, `dir` ← direction, `tmr` ← D−1, go to DELAY.
- DELAY:
  - Same-direction request held: if `tmr == 0`, step, `tmr` ← P−1, go to REPEAT; else `tmr` decrements.
- REPEAT:
  - Same-direction request held: if `tmr == 0`, step, `tmr` ← P−1; else `tmr` decrements.
- Leaving DELAY/REPEAT:
  - Request removed, or both buttons high: go to IDLE with no step.
  - Opposite-direction request: treated as a new press. Step in the new direction, `dir` updated, `tmr` ← D−1, state DELAY.
- Step rules (saturating):
  - Increase: `ex_init` ← `ex_init`+1 only if `ex_init < MAX_VAL`.
  - Decrease: `ex_init` ← `ex_init`−1 only if `ex_init > MIN_VAL`.
  - A step blocked by saturation changes nothing and gives no `step_pulse`, but the FSM timing proceeds unchanged.
  - No wrap-around under any input.
- Lock:
  - While `lock` is high, no step occurs and the FSM is forced to IDLE.
  - On the first cycle with `lock` low and a request present, a new press is taken (IDLE rule).
- Reset:
  - `ex_init` = INIT_VAL, FSM = IDLE, `tmr` = 0, `step_pulse` = 0, `at_min`/`at_max` per INIT_VAL.
  - Reset has priority over everything, including mid-repeat.
  - Power-up (simulation initial) values equal the reset values.

## Timing
- Request sampled at rising edge k: new `ex_init` and `step_pulse` are visible from edge k onward (1-cycle latency). `at_min`/`at_max` follow in the same cycle as `ex_init`.
- Request held continuously from sample cycle n: steps occur at sample cycles n, n+D, n+D+P, n+D+2P, …
- A one-cycle pulse produces exactly one step.
- `lock` asserted in cycle m blocks any step at edge m.

## Test plan
- Reset sequence: assert `reset` 2 cycles, then release → `ex_init` = 16, `at_min` = `at_max` = `step_pulse` = 0.
- Single 1-cycle `ex_increase` pulse from 16 → `ex_init` = 17 next cycle, exactly one `step_pulse`, no further steps over 20 idle cycles.
- Hold `ex_increase` 20 cycles from 16 (D=8, P=4) → steps at relative cycles 0, 8, 12, 16, final `ex_init` = 20. Then switch directly to `ex_decrease` → immediate step to 19, next step 8 cycles later.
- Hold `ex_increase` from 28 for 40 cycles → stops at 30, `at_max` = 1, no `step_pulse` after reaching 30. Mirror test: `ex_decrease` to 2 sets `at_min`.
- Both buttons high 10 cycles → `ex_init` unchanged, FSM stays IDLE.
- Hold increase, assert `lock` at relative cycle 5 for 6 cycles → no step during lock; step on the first unlocked cycle, then the next step D cycles later. Assert `reset` mid-REPEAT → 16 next cycle, IDLE.
